// File: rtl/input_assembler.sv
// Reassembles two 9-bit pin beats (low half first) into an 18-bit element, widened to 32 bits.
// Define INPUT_ASSEMBLER_SIGN_EXT_EN to sign-extend elements; otherwise they are zero-extended.
module input_assembler #(
  parameter int unsigned FRAME_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int unsigned CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    LO,
    HI,
    FULL
  } state_t;

  state_t        state, state_nxt;
  logic [8:0]    lo_buf;
  logic [CW-1:0] count;
  logic [31:0]   data_q;
  logic [13:0]   ext;
  logic          in_acc;
  logic          out_acc;

  always_comb begin
    out_valid = (state == FULL);
    out_last  = out_valid && (count == LAST_IDX);
    out_data  = data_q;
    // A held element frees its slot in the same cycle it is consumed.
    in_ready  = rst_n && ((state != FULL) || out_ready);
    in_acc    = in_valid && in_ready;
    out_acc   = out_valid && out_ready;
  end

  always_comb begin
`ifdef INPUT_ASSEMBLER_SIGN_EXT_EN
    ext = {14{in_data[8]}};
`else
    ext = '0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LO:      if (in_acc) state_nxt = HI;
      HI:      if (in_acc) state_nxt = FULL;
      FULL:    if (out_acc) state_nxt = in_acc ? HI : LO;
      default: state_nxt = LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LO;
      lo_buf <= '0;
      count  <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (in_acc && (state != HI))
        lo_buf <= in_data;
      if (in_acc && (state == HI))
        data_q <= {ext, in_data, lo_buf};
      if (out_acc)
        count <= (count == LAST_IDX) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: doc/input_assembler.md
# input_assembler

Input-side counterpart of the matrix unit's narrow output path. It accepts operand data from the 9-bit pin bus as two beats per word, lower half first and then upper half. It reassembles each pair into one 18-bit element, widens it to 32 bits, and presents it to the matrix core over a valid/ready handshake. It also counts elements per operand frame and marks the last element of each frame.

## Interface
- FRAME_WORDS, default 4: elements per operand frame (2x2 matrix); must be ≥ 2.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  9  one half-element beat from pins.
- in_valid  in  1  in_data holds a beat.
- in_ready  out  1  block accepts a beat this cycle.
- out_data  out  32  assembled element, widened per Configuration.
- out_valid  out  1  out_data/out_last valid.
- out_ready  in  1  core accepts the element this cycle.
- out_last  out  1  element is the final one of the current frame.

## Operation
- A beat is accepted on a cycle with in_valid && in_ready. An element is consumed on a cycle with out_valid && out_ready.
- FSM states:
  - LO: waiting for the lower beat.
  - HI: lower beat held in an internal 9-bit register, waiting for the upper beat.
  - FULL: element registered, out_valid=1.
- State transitions:
  - LO → HI on beat accept; the beat is stored as lo_buf.
  - HI → FULL on beat accept. out_data[17:0] = {in_data, lo_buf}. out_data[31:18] is set per the macro.
  - FULL, output consumed, no beat accepted → LO.
  - FULL, output consumed, beat accepted in the same cycle → HI; that beat becomes the new lo_buf.
  - FULL, not consumed → hold. out_data, out_valid and out_last stay stable.
- in_ready is 1 in LO and HI. In FULL it equals out_ready, which is combinational pass-through. in_ready is 0 while rst_n=0.
- Frame counter, width $clog2(FRAME_WORDS):
  - Increments on each consumed element.
  - Wraps to 0 after the element at FRAME_WORDS-1 is consumed.
  - out_last = out_valid && (count == FRAME_WORDS-1).
- A stalled in_valid between the lower and upper beats is legal. The block waits in HI indefinitely.
- Beats offered while in_ready=0 are not taken. The sender must hold them.

## Timing
- Reset values: state LO, lo_buf 0, count 0, out_data 0, out_valid 0, out_last 0.
- Latency: lower beat accepted at edge N, upper beat at edge N+1, so out_valid is high from cycle N+2 (registered output).
- Throughput: one element per 2 cycles sustained, which matches the 2-beat bus limit. There are no bubbles when out_ready is held at 1.
- The output is a registered stage. out_ready affects in_ready combinationally, but no output register depends combinationally on out_ready.
- Reset asserted mid-operation:
  - Discards a partial word in HI and any held element in FULL.
  - Clears the frame count.
  - The next accepted beat after reset is treated as a lower half.
- Reset with out_valid high drops out_valid on the following edge. The element is lost and is not re-presented.

## Configuration
- INPUT_ASSEMBLER_SIGN_EXT_EN defined: out_data[31:18] = {14{out_data[17]}}, so elements are signed 18-bit two's complement.
- Not defined: out_data[31:18] = 0, so elements are unsigned.
- The macro has no other effect on timing or handshake.

## Test plan
- Reset, then beats 0x0AB and 0x1CD with out_ready=1:
  - out_valid rises at cycle 2.
  - out_data = 0x00039AAB without the macro, 0xFFFF9AAB with it.
- Backpressure: hold out_ready=0 after an element is formed.
  - in_ready=0, and out_data stays stable for 5 cycles.
  - Raising out_ready consumes the element and accepts a new lower beat in the same cycle. State goes to HI.
- Frame: stream 8 elements (values 1..8 in lower beats, upper beats 0) with FRAME_WORDS=4.
  - out_last is high only on elements 4 and 8.
  - The count wraps to 0.
- Gap: lower beat 0x155, in_valid low for 3 cycles, then upper beat 0x000.
  - out_data[17:0]=0x00155, with exactly one element produced.
- Reset mid-word: lower beat 0x1FF, then rst_n=0 for 1 cycle, then beats 0x001 and 0x002.
  - out_data[17:0]=0x00401.
  - Count restarts, and out_last occurs only on the 4th element after reset.
